// File: rtl/io_uart_pkg.sv
// ============================================================================
// Module      : io_uart_pkg
// Description : Shared I/O-bus macros and the register map, FSM state type
//               and divisor helper for the io_uart transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef IO_UART_DEFINES_SVH
`define IO_UART_DEFINES_SVH
`define RamEnable           1'b1
`define RamWrite            1'b1
`define Zero                32'h0000_0000
`define IO_UART_BASE        32'h7000_0000
`define IO_UART_REG_DATA    2'd0
`define IO_UART_REG_STATUS  2'd1
`define IO_UART_REG_DIV     2'd2
`define IO_UART_REG_RSVD    2'd3
`define IO_UART_ST_IDLE     3'd0
`define IO_UART_ST_START    3'd1
`define IO_UART_ST_DATA     3'd2
`define IO_UART_ST_PARITY   3'd3
`define IO_UART_ST_STOP     3'd4
`endif

package io_uart_pkg;

    localparam logic [1:0] c_reg_data   = `IO_UART_REG_DATA;
    localparam logic [1:0] c_reg_status = `IO_UART_REG_STATUS;
    localparam logic [1:0] c_reg_div    = `IO_UART_REG_DIV;

    typedef enum logic [2:0] {
        ST_IDLE   = `IO_UART_ST_IDLE,
        ST_START  = `IO_UART_ST_START,
        ST_DATA   = `IO_UART_ST_DATA,
        ST_PARITY = `IO_UART_ST_PARITY,
        ST_STOP   = `IO_UART_ST_STOP
    } tx_state_e;

    // A divisor below 2 cannot produce a usable bit time.
    function automatic logic [15:0] clamp_div(input logic [15:0] value);
        return (value < 16'd2) ? 16'd2 : value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/io_uart_tx_fifo.sv
// ============================================================================
// Module      : uart_tx_fifo
// Description : First-word fall-through byte FIFO with wrap-bit pointers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [c_aw:0] wptr_q, wptr_d;
    logic [c_aw:0] rptr_q, rptr_d;
    logic [7:0]    mem_q [DEPTH];
    logic          w_do_push;
    logic          w_do_pop;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[c_aw] != rptr_q[c_aw]) &&
                   (wptr_q[c_aw-1:0] == rptr_q[c_aw-1:0]);
    assign dout  = mem_q[rptr_q[c_aw-1:0]];

    // A pop frees the slot the simultaneous push lands in, even when full.
    always_comb begin
        w_do_pop  = pop && !empty;
        w_do_push = push && (!full || w_do_pop);
        wptr_d    = wptr_q + {{c_aw{1'b0}}, w_do_push};
        rptr_d    = rptr_q + {{c_aw{1'b0}}, w_do_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wptr_q[c_aw-1:0]] <= din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/io_uart.sv
// ============================================================================
// Module      : io_uart
// Description : Memory-mapped UART transmitter (DATA/STATUS/DIV registers,
//               TX FIFO, frame FSM). Define IO_UART_PARITY_EN for 8E1 frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_uart
    import io_uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ioCe,
    input  logic        ioWe,
    input  logic [31:0] ioAddr,
    input  logic [31:0] ioWtData,
    output logic [31:0] ioRdData,
    output logic        txd,
    output logic        txIrq
);

`ifdef IO_UART_PARITY_EN
    localparam logic c_parity_flag = 1'b1;
`else
    localparam logic c_parity_flag = 1'b0;
`endif

    logic        w_wr, w_rd, w_push, w_pop, w_start, w_bit_end, w_busy;
    logic        w_full, w_empty;
    logic [1:0]  w_sel;
    logic [7:0]  w_fifo_dout;
    logic        unused_bits;

    tx_state_e   state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [15:0] bit_div_q, bit_div_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        ovf_q, ovf_d;
    logic        txd_q, txd_d;
`ifdef IO_UART_PARITY_EN
    logic        par_q, par_d;
`endif

    assign w_wr        = (ioCe == `RamEnable) && (ioWe == `RamWrite);
    assign w_rd        = (ioCe == `RamEnable) && (ioWe != `RamWrite);
    assign w_sel       = ioAddr[3:2];
    assign w_push      = w_wr && (w_sel == c_reg_data);
    assign w_busy      = (state_q != ST_IDLE);
    assign w_bit_end   = (cnt_q == 16'd0);
    assign txd         = txd_q;
    assign txIrq       = w_empty && !w_busy;
    assign unused_bits = ^{ioAddr[31:4], ioAddr[1:0], ioWtData[31:16]};

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (ioWtData[7:0]),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        div_d = div_q;
        if (w_wr && (w_sel == c_reg_div)) begin
            div_d = clamp_div(ioWtData[15:0]);
        end
        ovf_d = ovf_q;
        if (w_wr && (w_sel == c_reg_status)) begin
            ovf_d = 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        ioRdData = `Zero;
        if (w_rd) begin
            case (w_sel)
                c_reg_status: ioRdData = {27'd0, c_parity_flag, ovf_q, w_busy, w_empty, w_full};
                c_reg_div:    ioRdData = {16'd0, div_q};
                default:      ioRdData = `Zero;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_div_d = bit_div_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        w_start   = 1'b0;
        w_pop     = 1'b0;
`ifdef IO_UART_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            ST_IDLE:  w_start = !w_empty;
            ST_START: if (w_bit_end) begin
                state_d   = ST_DATA;
                bit_idx_d = 3'd0;
            end
            ST_DATA: if (w_bit_end) begin
                if (bit_idx_q == 3'd7) begin
`ifdef IO_UART_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end else begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    shift_d   = {1'b0, shift_q[7:1]};
                end
            end
`ifdef IO_UART_PARITY_EN
            ST_PARITY: if (w_bit_end) state_d = ST_STOP;
`endif
            ST_STOP: if (w_bit_end) begin
                if (!w_empty) w_start = 1'b1;
                else          state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_busy) begin
            cnt_d = w_bit_end ? (bit_div_q - 16'd1) : (cnt_q - 16'd1);
        end

        // Frame start: DIV is sampled here so mid-frame writes wait a frame.
        if (w_start) begin
            state_d   = ST_START;
            w_pop     = 1'b1;
            shift_d   = w_fifo_dout;
            bit_div_d = div_q;
            cnt_d     = div_q - 16'd1;
`ifdef IO_UART_PARITY_EN
            par_d     = ^w_fifo_dout;
`endif
        end

        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[0];
`ifdef IO_UART_PARITY_EN
            ST_PARITY: txd_d = par_d;
`endif
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            div_q     <= DIV_RESET;
            bit_div_q <= DIV_RESET;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            ovf_q     <= 1'b0;
            txd_q     <= 1'b1;
`ifdef IO_UART_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_div_q <= bit_div_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            ovf_q     <= ovf_d;
            txd_q     <= txd_d;
`ifdef IO_UART_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_io_uart.sv
// ============================================================================
// Module      : tb_io_uart
// Description : Directed self-checking bench for io_uart (either frame format).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_uart;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ioCe = 1'b0;
    logic        ioWe = 1'b0;
    logic [31:0] ioAddr = 32'd0;
    logic [31:0] ioWtData = 32'd0;
    logic [31:0] ioRdData;
    logic        txd;
    logic        txIrq;

`ifdef IO_UART_PARITY_EN
    localparam int          NB = 11;
    localparam logic [31:0] PB = 32'h10;
`else
    localparam int          NB = 10;
    localparam logic [31:0] PB = 32'h00;
`endif

    int         checks = 0;
    int         errors = 0;
    int         t = 0;
    logic [7:0] fb[$];
    int         fd[$];

    always #5 clk = ~clk;

    io_uart #(
        .FIFO_DEPTH (8),
        .DIV_RESET  (16'd434)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ioCe     (ioCe),
        .ioWe     (ioWe),
        .ioAddr   (ioAddr),
        .ioWtData (ioWtData),
        .ioRdData (ioRdData),
        .txd      (txd),
        .txIrq    (txIrq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] data);
        ioCe     = 1'b1;
        ioWe     = 1'b1;
        ioAddr   = 32'h7000_0000 | {28'd0, off, 2'b00};
        ioWtData = data;
        tick();
        ioCe = 1'b0;
        ioWe = 1'b0;
    endtask

    task automatic rd(input logic [1:0] off, input logic [31:0] exp, input string tag);
        ioCe   = 1'b1;
        ioWe   = 1'b0;
        ioAddr = 32'h7000_0000 | {28'd0, off, 2'b00};
        #1;
        check(tag, ioRdData, exp);
        ioCe   = 1'b0;
        ioAddr = 32'd0;
    endtask

    function automatic logic exp_txd(input int tt);
        int rem = tt;
        for (int i = 0; i < fb.size(); i++) begin
            if (rem < NB * fd[i]) begin
                int b = rem / fd[i];
                if (b == 0)                 return 1'b0;
                if (b <= 8)                 return fb[i][b-1];
                if (NB == 11 && b == 9)     return ^fb[i];
                return 1'b1;
            end
            rem -= NB * fd[i];
        end
        return 1'b1;
    endfunction

    // t == 0 is the first cycle after the edge where the first frame's START begins.
    task automatic run_stream(input string tag);
        int total = 0;
        for (int i = 0; i < fd.size(); i++) total += NB * fd[i];
        while (t < total) begin
            if (t >= 0) check(tag, {31'd0, txd}, {31'd0, exp_txd(t)});
            tick();
        end
        check({tag, "_end_txd"}, {31'd0, txd}, 32'd1);
        check({tag, "_end_irq"}, {31'd0, txIrq}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_irq", {31'd0, txIrq}, 32'd1);
        check("rst_rddata", ioRdData, 32'd0);
        rd(2'd1, 32'h2 | PB, "rst_status");
        rd(2'd2, 32'd434, "rst_div");

        // 0x55 at DIV=4
        wr(2'd2, 32'd4);
        fb.delete(); fd.delete();
        fb.push_back(8'h55); fd.push_back(4);
        wr(2'd0, 32'h55);
        t = -1;
        check("queued_irq", {31'd0, txIrq}, 32'd0);
        rd(2'd1, PB, "queued_status");
        run_stream("frame55");
        rd(2'd1, 32'h2 | PB, "idle_status");

        // divisor clamp, reserved offset, non-read accesses
        wr(2'd2, 32'd0);
        rd(2'd2, 32'd2, "div0_clamp");
        wr(2'd2, 32'd1);
        rd(2'd2, 32'd2, "div1_clamp");
        wr(2'd2, 32'hFFFF_0003);
        rd(2'd2, 32'd3, "div_upper_ignored");
        wr(2'd3, 32'h0000_1234);
        rd(2'd2, 32'd3, "rsvd_wr_div");
        rd(2'd1, 32'h2 | PB, "rsvd_wr_status");
        rd(2'd3, 32'd0, "rsvd_read");
        rd(2'd0, 32'd0, "data_read");
        ioAddr = 32'h7000_0008;
        #1;
        check("ce_inactive_read", ioRdData, 32'd0);
        ioAddr = 32'd0;

        // DIV change mid-frame applies to the next frame
        wr(2'd2, 32'd4);
        fb.delete(); fd.delete();
        fb.push_back(8'hC3); fd.push_back(4);
        fb.push_back(8'h3C); fd.push_back(8);
        wr(2'd0, 32'hC3);
        t = -1;
        wr(2'd0, 32'h3C);
        tick(); tick();
        wr(2'd2, 32'd8);
        rd(2'd2, 32'd8, "div_mid_frame_read");
        run_stream("div_change");

        // fill past capacity while the first frame is on the line
        wr(2'd2, 32'd100);
        fb.delete(); fd.delete();
        for (int i = 0; i < 9; i++) begin
            fb.push_back(8'hA0 + 8'(i));
            fd.push_back(100);
        end
        wr(2'd0, 32'hA0);
        t = -1;
        for (int i = 1; i < 9; i++) wr(2'd0, 32'hA0 + i);
        rd(2'd1, 32'h5 | PB, "full_status");
        wr(2'd0, 32'hEE);
        rd(2'd1, 32'hD | PB, "overflow_status");
        wr(2'd1, 32'd0);
        rd(2'd1, 32'h5 | PB, "overflow_cleared");
        run_stream("burst");
        rd(2'd1, 32'h2 | PB, "burst_done_status");

        // parity frame 0x07
        wr(2'd2, 32'd3);
        fb.delete(); fd.delete();
        fb.push_back(8'h07); fd.push_back(3);
        wr(2'd0, 32'h07);
        t = -1;
        run_stream("frame07");

        // reset during DATA with a byte still queued
        wr(2'd2, 32'd4);
        wr(2'd0, 32'h00);
        t = -1;
        wr(2'd0, 32'hFF);
        while (t < 6) tick();
        check("pre_rst_data_bit", {31'd0, txd}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_txd", {31'd0, txd}, 32'd1);
        check("mid_rst_irq", {31'd0, txIrq}, 32'd1);
        rd(2'd1, 32'h2 | PB, "mid_rst_status");
        rd(2'd2, 32'd434, "mid_rst_div");
        repeat (5) tick();
        check("post_rst_flushed_txd", {31'd0, txd}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
